// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: frame-buffer read bus (master = reader, slave = buffer)
interface vga_frame_reader_if #(parameter int ADDR_W = 17);
  logic rd_en;
  logic rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0] rd_data;
  modport master(output rd_en, rd_bank, rd_addr, input rd_data);
  modport slave(input rd_en, rd_bank, rd_addr, output rd_data);
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 2x-upscaled RGB565 frame-buffer reader with latency-matched syncs and vblank bank ping-pong
module vga_frame_reader #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic h_sync_in,
  input  logic v_sync_in,
  input  logic de_in,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic wr_frame_done,
  output logic wr_bank,
  output logic wr_ready,
  vga_frame_reader_if.master fb,
  output logic h_sync,
  output logic v_sync,
  output logic DE,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic frame_start,
  output logic [7:0] drop_cnt
);
  localparam int L = RD_LAT + 2;
  typedef enum logic {SCAN, VBLANK} state_t;
  state_t state, state_n;
  logic pending, pending_n, rd_bank_n, frame_start_n, swap, drop, in_img, in_vis;
  logic [7:0] drop_cnt_n;
  logic [9:0] xs, ys;
  logic [RD_LAT-1:0] img_d;
  logic [L-1:0] hs_d, vs_d, de_d;
  logic unused;
  assign xs = x_pixel >> SCALE_SHIFT;
  assign ys = y_pixel >> SCALE_SHIFT;
  assign in_img = de_in && xs < 10'(IMG_W) && ys < 10'(IMG_H);
  assign in_vis = y_pixel < 10'(V_ACTIVE);
  assign wr_bank = ~fb.rd_bank;
  assign wr_ready = !pending;
  assign h_sync = hs_d[L-1];
  assign v_sync = vs_d[L-1];
  assign DE = de_d[L-1];
  assign unused = ^{fb.rd_data[11], fb.rd_data[6:5], fb.rd_data[0]};
  always_comb begin
    state_n = in_vis ? SCAN : VBLANK;
    swap = state == SCAN && !in_vis && (pending || wr_frame_done);
    drop = wr_frame_done && pending && !swap;
    pending_n = swap ? 1'b0 : pending | wr_frame_done;
    drop_cnt_n = drop && drop_cnt != 8'hFF ? drop_cnt + 8'd1 : drop_cnt;
    rd_bank_n = fb.rd_bank ^ swap;
    frame_start_n = state == VBLANK && in_vis;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      pending <= 1'b0;
      fb.rd_bank <= 1'b0;
      drop_cnt <= 8'd0;
      frame_start <= 1'b0;
      fb.rd_en <= 1'b0;
      fb.rd_addr <= '0;
      img_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
      de_d <= '0;
      red <= 4'd0;
      green <= 4'd0;
      blue <= 4'd0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      fb.rd_bank <= rd_bank_n;
      drop_cnt <= drop_cnt_n;
      frame_start <= frame_start_n;
      fb.rd_en <= in_img;
      if (in_img) fb.rd_addr <= ADDR_W'(32'(ys) * 32'(IMG_W) + 32'(xs));
      img_d <= RD_LAT'({img_d, fb.rd_en});
      hs_d <= L'({hs_d, h_sync_in});
      vs_d <= L'({vs_d, v_sync_in});
      de_d <= L'({de_d, de_in});
      red <= img_d[RD_LAT-1] ? fb.rd_data[15:12] : 4'd0;
      green <= img_d[RD_LAT-1] ? fb.rd_data[10:7] : 4'd0;
      blue <= img_d[RD_LAT-1] ? fb.rd_data[4:1] : 4'd0;
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: directed vectors and bank sequences for vga_frame_reader
module tb_vga_frame_reader;
  logic clk = 1'b0;
  logic reset, h_sync_in, v_sync_in, de_in, wr_frame_done;
  logic [9:0] x_pixel, y_pixel;
  logic wr_bank, wr_ready, h_sync, v_sync, DE, frame_start;
  logic [3:0] red, green, blue;
  logic [7:0] drop_cnt;
  int errors = 0;
  int checks = 0;
  vga_frame_reader_if #(.ADDR_W(17)) fb();
  vga_frame_reader dut (
    .clk(clk), .reset(reset), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .wr_frame_done(wr_frame_done), .wr_bank(wr_bank),
    .wr_ready(wr_ready), .fb(fb), .h_sync(h_sync), .v_sync(v_sync), .DE(DE), .red(red),
    .green(green), .blue(blue), .frame_start(frame_start), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0] x, y;
    logic de;
    logic [15:0] data;
    logic en;
    int addr;
    logic [3:0] r, g, b;
    logic de_o;
  } vec_t;
  vec_t vecs[7];
  logic [2:0] hist[1000];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_done;
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
  endtask
  task automatic at_line(input int y);
    y_pixel = 10'(y);
    tick();
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_bank"}, fb.rd_bank, 0);
    chk({tag, "_wr_bank"}, wr_bank, 1);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_rd_en"}, fb.rd_en, 0);
    chk({tag, "_rd_addr"}, fb.rd_addr, 0);
    chk({tag, "_syncs_de"}, {h_sync, v_sync, DE}, 3'b110);
    chk({tag, "_rgb"}, {red, green, blue}, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask
  initial begin
    vecs[0] = '{x:0,   y:0,   de:1, data:16'hF800, en:1, addr:0,     r:4'hF, g:4'h0, b:4'h0, de_o:1};
    vecs[1] = '{x:639, y:479, de:1, data:16'h07E0, en:1, addr:76799, r:4'h0, g:4'hF, b:4'h0, de_o:1};
    vecs[2] = '{x:3,   y:5,   de:1, data:16'h001F, en:1, addr:641,   r:4'h0, g:4'h0, b:4'hF, de_o:1};
    vecs[3] = '{x:3,   y:5,   de:0, data:16'hFFFF, en:0, addr:641,   r:4'h0, g:4'h0, b:4'h0, de_o:0};
    vecs[4] = '{x:640, y:0,   de:1, data:16'hFFFF, en:0, addr:641,   r:4'h0, g:4'h0, b:4'h0, de_o:1};
    vecs[5] = '{x:100, y:200, de:1, data:16'hA5C3, en:1, addr:32050, r:4'hA, g:4'hB, b:4'h1, de_o:1};
    vecs[6] = '{x:1,   y:1,   de:1, data:16'hFFFF, en:1, addr:0,     r:4'hF, g:4'hF, b:4'hF, de_o:1};
    reset = 1'b1;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    de_in = 1'b0;
    wr_frame_done = 1'b0;
    x_pixel = '0;
    y_pixel = '0;
    fb.rd_data = '0;
    #2;
    chk_reset_state("rst");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      x_pixel = vecs[i].x;
      y_pixel = vecs[i].y;
      de_in = vecs[i].de;
      fb.rd_data = vecs[i].data;
      tick();
      chk($sformatf("v%0d_rd_en", i), fb.rd_en, vecs[i].en);
      chk($sformatf("v%0d_rd_addr", i), fb.rd_addr, vecs[i].addr);
      de_in = 1'b0;
      tick();
      tick();
      chk($sformatf("v%0d_de_early", i), DE, 0);
      tick();
      chk($sformatf("v%0d_de", i), DE, vecs[i].de_o);
      chk($sformatf("v%0d_rgb", i), {red, green, blue}, {vecs[i].r, vecs[i].g, vecs[i].b});
      repeat (3) tick();
    end
    x_pixel = 10'd700;
    y_pixel = '0;
    for (int j = 0; j < 1000; j++) begin
      hist[j] = 3'($urandom_range(0, 7));
      {h_sync_in, v_sync_in, de_in} = hist[j];
      tick();
      if (j >= 3) chk("sync_delay", {h_sync, v_sync, DE}, hist[j-3]);
    end
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    de_in = 1'b0;
    repeat (4) tick();
    at_line(100);
    pulse_done();
    chk("b_wr_ready_low", wr_ready, 0);
    chk("b_wr_bank", wr_bank, 1);
    at_line(479);
    chk("b_no_early_swap", fb.rd_bank, 0);
    at_line(480);
    chk("b_swap", fb.rd_bank, 1);
    chk("b_wr_bank_after", wr_bank, 0);
    chk("b_wr_ready_high", wr_ready, 1);
    at_line(481);
    chk("b_no_fs_vblank", frame_start, 0);
    at_line(0);
    chk("b_frame_start", frame_start, 1);
    tick();
    chk("b_frame_start_one", frame_start, 0);
    at_line(100);
    pulse_done();
    tick();
    pulse_done();
    chk("c_drop1", drop_cnt, 1);
    chk("c_wr_ready_low", wr_ready, 0);
    at_line(480);
    chk("c_single_swap", fb.rd_bank, 0);
    at_line(481);
    chk("c_bank_hold", fb.rd_bank, 0);
    at_line(490);
    pulse_done();
    chk("c_vb_pending", wr_ready, 0);
    at_line(524);
    at_line(0);
    at_line(300);
    chk("c_no_midframe_swap", fb.rd_bank, 0);
    at_line(480);
    chk("c_late_swap", fb.rd_bank, 1);
    chk("c_late_ready", wr_ready, 1);
    chk("c_drop_still1", drop_cnt, 1);
    at_line(0);
    at_line(479);
    y_pixel = 10'd480;
    pulse_done();
    chk("d_swap_same_cycle", fb.rd_bank, 0);
    chk("d_no_drop", drop_cnt, 1);
    chk("d_ready", wr_ready, 1);
    at_line(0);
    at_line(100);
    pulse_done();
    y_pixel = 10'd480;
    pulse_done();
    chk("d_pending_plus_pulse_swap", fb.rd_bank, 1);
    chk("d_pending_plus_pulse_drop", drop_cnt, 1);
    chk("d_pending_plus_pulse_ready", wr_ready, 1);
    at_line(0);
    wr_frame_done = 1'b1;
    repeat (300) tick();
    wr_frame_done = 1'b0;
    chk("d_drop_saturate", drop_cnt, 255);
    at_line(200);
    chk("e_pending_before", wr_ready, 0);
    reset = 1'b1;
    #1;
    chk_reset_state("e_rst");
    tick();
    reset = 1'b0;
    at_line(300);
    at_line(480);
    chk("e_no_swap", fb.rd_bank, 0);
    chk("e_ready", wr_ready, 1);
    at_line(0);
    chk("e_frame_start", frame_start, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
